// File: rtl/aes_mode_ctrl.sv
// rtl/aes_mode_ctrl.sv - ECB/CBC/CTR block-mode front end for the AES core with output FIFO
module aes_mode_ctrl #(
  parameter int BLK_W     = 128,
  parameter int KEY_W     = 256,
  parameter int CTR_W     = 32,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_load_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic [1:0]       cfg_type_i,
  input  logic [KEY_W-1:0] cfg_key_i,
  input  logic [BLK_W-1:0] cfg_iv_i,
  output logic             cfg_err_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [BLK_W-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BLK_W-1:0] out_data_o,
  output logic             busy_o,
  output logic             core_start_o,
  output logic [1:0]       core_type_o,
  output logic [KEY_W-1:0] core_key_o,
  output logic [BLK_W-1:0] core_text_o,
  input  logic             core_done_i,
  input  logic [BLK_W-1:0] core_text_i
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam logic [BLK_W-1:0] ONE = BLK_W'(1);
  // A shift of BLK_W yields 0, so the full-width counter case becomes all ones.
  localparam logic [BLK_W-1:0] CTR_MASK = (ONE << CTR_W) - ONE;
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, type_q;
  logic [KEY_W-1:0]   key_q;
  logic [BLK_W-1:0]   chain_q, data_q, result;
  logic               err_q;
  logic [BLK_W-1:0]   mem [OUT_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full, accept, cfg_ok, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full   = (count == CNT_W'(OUT_DEPTH));
  assign accept      = in_valid_i && in_ready_o;
  assign cfg_ok      = cfg_load_i && (state_q == S_IDLE);
  assign push        = (state_q == S_WAIT) && core_done_i;
  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = (count != '0);
  assign out_data_o  = mem[rd_ptr];
  assign busy_o      = (state_q != S_IDLE) || (count != '0);
  assign cfg_err_o   = err_q;
  assign core_type_o = type_q;
  assign core_key_o  = key_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (core_done_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A simultaneous cfg_load_i takes priority over an input block.
  always_comb begin
    in_ready_o   = 1'b0;
    core_start_o = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_o   = !fifo_full && !cfg_load_i && !rst_i;
      S_ISSUE: core_start_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (mode_q)
      MODE_CBC: core_text_o = data_q ^ chain_q;
      MODE_CTR: core_text_o = chain_q;
      default:  core_text_o = data_q;
    endcase
    result = (mode_q == MODE_CTR) ? (core_text_i ^ data_q) : core_text_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= '0;
      type_q  <= '0;
      key_q   <= '0;
      chain_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= cfg_load_i && (state_q != S_IDLE);
      if (cfg_ok) begin
        mode_q  <= cfg_mode_i;
        type_q  <= cfg_type_i;
        key_q   <= cfg_key_i;
        chain_q <= cfg_iv_i;
      end
      if (accept) data_q <= in_data_i;
      if (push) begin
        if (mode_q == MODE_CBC)
          chain_q <= core_text_i;
        else if (mode_q == MODE_CTR)
          chain_q <= (chain_q & ~CTR_MASK) | ((chain_q + ONE) & CTR_MASK);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
